// File: rtl/handshake_pkg.sv
// Shared types and default parameters for the four-phase req/ack handshake unit.
package handshake_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } snd_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_ACK  = 1'b1
    } rcv_state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_RD_DIV      = 4;

endpackage

// File: rtl/handshake_if.sv
// Control-side bundle of the handshake unit: transfer request in, notification/busy out.
interface handshake_if;
    logic start;
    logic read_it;
    logic done;

    modport master (output start, input read_it, input done);
    modport slave  (input start, output read_it, output done);
endinterface

// File: rtl/sync_delay.sv
// Fixed-length flop chain that models synchronizer latency on one handshake wire.
module sync_delay #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh <= '0;
        end else begin
            r_sh[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                r_sh[i] <= r_sh[i-1];
            end
        end
    end

    assign q = r_sh[STAGES-1];

endmodule

// File: rtl/handshake_unit.sv
// Four-phase handshake between a full-rate sender FSM and an enable-gated receiver FSM,
// with req and ack each crossing through a sync_delay chain.
module handshake_unit
    import handshake_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int RD_DIV      = DEF_RD_DIV
) (
    input  logic        clk,
    input  logic        rst,
    handshake_if.slave  hs
);

    localparam int CNT_W = (RD_DIV > 1) ? $clog2(RD_DIV) : 1;

    snd_state_t       r_state;
    rcv_state_t       r_rstate;
    logic             r_req;
    logic             r_ack;
    logic             r_done;
    logic             r_read_it;
    logic [CNT_W-1:0] r_cnt;
    logic             w_rd_en;
    logic             w_req_s;
    logic             w_ack_s;

    // Read-side enable: one pulse every RD_DIV cycles, on the last count.
    assign w_rd_en = (r_cnt == CNT_W'(RD_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_rd_en) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    sync_delay #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (r_req),
        .q   (w_req_s)
    );

    sync_delay #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (r_ack),
        .q   (w_ack_s)
    );

    // Sender: done lags the state by one cycle so it rises the edge after start is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state != IDLE);
            unique case (r_state)
                IDLE: begin
                    if (hs.start) begin
                        r_state <= REQ;
                        r_req   <= 1'b1;
                    end
                end
                REQ: begin
                    if (w_ack_s) begin
                        r_state <= DROP;
                        r_req   <= 1'b0;
                    end
                end
                DROP: begin
                    if (!w_ack_s) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    // Receiver: moves only on rd_en; read_it marks the accepting transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate  <= R_IDLE;
            r_ack     <= 1'b0;
            r_read_it <= 1'b0;
        end else begin
            r_read_it <= 1'b0;
            if (w_rd_en) begin
                unique case (r_rstate)
                    R_IDLE: begin
                        if (w_req_s) begin
                            r_rstate  <= R_ACK;
                            r_ack     <= 1'b1;
                            r_read_it <= 1'b1;
                        end
                    end
                    R_ACK: begin
                        if (!w_req_s) begin
                            r_rstate <= R_IDLE;
                            r_ack    <= 1'b0;
                        end
                    end
                    default: begin
                        r_rstate <= R_IDLE;
                        r_ack    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign hs.done    = r_done;
    assign hs.read_it = r_read_it;

endmodule

// File: tb/tb_handshake_unit.sv
// Directed bench for handshake_unit: default build (S=2, D=4) and a fast build (S=1, D=1).
module tb_handshake_unit;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    handshake_if ifa ();
    handshake_if ifb ();

    handshake_unit #(.SYNC_STAGES(2), .RD_DIV(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .hs  (ifa.slave)
    );

    handshake_unit #(.SYNC_STAGES(1), .RD_DIV(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .hs  (ifb.slave)
    );

    int vectors = 0;
    int errs    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic get_done(input int sel);
        return (sel == 0) ? ifa.done : ifb.done;
    endfunction

    function automatic logic get_rd(input int sel);
        return (sel == 0) ? ifa.read_it : ifb.read_it;
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) ifa.start = v;
        else          ifb.start = v;
    endtask

    // Expect n idle cycles: done low and no read_it.
    task automatic quiet(input string tag, input int sel, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (get_done(sel) !== 1'b0 || get_rd(sel) !== 1'b0) bad++;
        end
        check(tag, bad, 0);
    endtask

    // One transfer from a 1-cycle start pulse; optional second start pulse at high-cycle 'poke'.
    task automatic xfer(input string tag, input int sel, input int lo, input int hi, input int poke);
        int hi_cnt = 0;
        int rd_cnt = 0;
        @(negedge clk);
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        check({tag, "_done_before_rise"}, get_done(sel), 0);
        @(negedge clk);
        check({tag, "_done_rise"}, get_done(sel), 1);
        while (get_done(sel) === 1'b1 && hi_cnt < 200) begin
            hi_cnt++;
            if (get_rd(sel) === 1'b1) rd_cnt++;
            set_start(sel, (hi_cnt == poke));
            @(negedge clk);
        end
        set_start(sel, 1'b0);
        check({tag, "_no_timeout"}, (hi_cnt < 200), 1);
        check({tag, "_high_time_in_range"}, (hi_cnt >= lo && hi_cnt <= hi), 1);
        check({tag, "_read_it_count"}, rd_cnt, 1);
    endtask

    initial begin
        int rises;
        int rd_cnt;
        int guard;
        logic prev;

        rst = 1'b1;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_a_done", ifa.done, 0);
        check("rst_a_read_it", ifa.read_it, 0);
        check("rst_b_done", ifb.done, 0);
        check("rst_b_read_it", ifb.read_it, 0);
        rst = 1'b0;
        quiet("idle_a_20", 0, 20);
        quiet("idle_b_20", 1, 20);

        xfer("a_single", 0, 12, 18, 0);
        xfer("a_second", 0, 12, 18, 0);

        xfer("a_start_ignored", 0, 12, 18, 3);
        quiet("a_no_queued_xfer", 0, 10);

        // Reset while the sender is in REQ.
        @(negedge clk);
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        @(negedge clk);
        check("a_mid_done_high", ifa.done, 1);
        rst = 1'b1;
        @(negedge clk);
        check("a_mid_rst_done", ifa.done, 0);
        check("a_mid_rst_read_it", ifa.read_it, 0);
        rst = 1'b0;
        quiet("a_after_rst_quiet", 0, 20);
        xfer("a_after_rst", 0, 12, 18, 0);

        xfer("b_fast_1", 1, 6, 8, 0);
        xfer("b_fast_2", 1, 6, 8, 0);

        // Start held high: back-to-back transfers on the fast build.
        rises  = 0;
        rd_cnt = 0;
        prev   = ifb.done;
        @(negedge clk);
        ifb.start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ifb.done === 1'b1 && prev === 1'b0) rises++;
            if (ifb.read_it === 1'b1) rd_cnt++;
            prev = ifb.done;
        end
        ifb.start = 1'b0;
        check("b_held_multi_xfer", (rises >= 2), 1);
        check("b_held_one_read_per_xfer", (rd_cnt >= rises - 1 && rd_cnt <= rises), 1);
        guard = 0;
        while (ifb.done === 1'b1 && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        check("b_held_drains", (guard < 50), 1);
        quiet("b_held_quiet", 1, 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
